// File: rtl/mac_pipe_acc_if.sv
// Operand/result bundle for mac_pipe_acc: master drives operands and
// control, slave (the MAC) returns the accumulator and frame status.
interface mac_pipe_acc_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              in_last;
    logic              clr;
    logic [ACC_W-1:0]  acc;
    logic              out_valid;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    modport master (
        output in_valid, a, b, in_last, clr,
        input  acc, out_valid, cnt, ovf
    );

    modport slave (
        input  in_valid, a, b, in_last, clr,
        output acc, out_valid, cnt, ovf
    );
endinterface

// File: rtl/mac_pipe_acc.sv
// Two-stage pipelined multiply-accumulate with framed dot products, term
// counter and sticky overflow. Define MAC_SAT_EN to saturate acc on overflow.
module mac_pipe_acc #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int CNT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic          clk,
    input  logic          rst,
    mac_pipe_acc_if.slave bus
);
    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    a_ext;
    logic [PW-1:0]    b_ext;
    logic [PW-1:0]    prod;
    logic [PW-1:0]    p;
    logic             v1;
    logic             last1;

    logic             first;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;
    logic             out_valid_q;

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] base;
    logic [ACC_W-1:0] sum_w;
    logic [ACC_W-1:0] sum_nxt;
    logic             carry;
    logic             ov;
    logic [CNT_W-1:0] cnt_nxt;

    // Operands are widened to the product width first, so the low PW bits
    // of an unsigned multiply give the correct signed product too.
    always_comb begin
        if (SIGNED != 0) begin
            a_ext = PW'($signed(bus.a));
            b_ext = PW'($signed(bus.b));
        end else begin
            a_ext = PW'(bus.a);
            b_ext = PW'(bus.b);
        end
        prod = a_ext * b_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
            p     <= '0;
        end else if (bus.clr) begin
            v1    <= 1'b0;
            last1 <= 1'b0;
        end else begin
            v1    <= bus.in_valid;
            last1 <= bus.in_valid & bus.in_last;
            if (bus.in_valid) begin
                p <= prod;
            end
        end
    end

    always_comb begin
        if (SIGNED != 0) begin
            ext = ACC_W'($signed(p));
        end else begin
            ext = ACC_W'(p);
        end
        base           = first ? '0 : acc_q;
        {carry, sum_w} = {1'b0, base} + {1'b0, ext};
        if (SIGNED != 0) begin
            ov = (base[ACC_W-1] == ext[ACC_W-1]) && (sum_w[ACC_W-1] != base[ACC_W-1]);
        end else begin
            ov = carry;
        end
        sum_nxt = sum_w;
`ifdef MAC_SAT_EN
        // Signed overflow direction follows the common operand sign.
        if (ov) begin
            if (SIGNED == 0) begin
                sum_nxt = '1;
            end else if (base[ACC_W-1]) begin
                sum_nxt = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum_nxt = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
`endif
        if (first) begin
            cnt_nxt = CNT_W'(1);
        end else if (cnt_q == '1) begin
            cnt_nxt = cnt_q;
        end else begin
            cnt_nxt = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            first       <= 1'b1;
        end else if (bus.clr) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            first       <= 1'b1;
        end else begin
            out_valid_q <= v1 & last1;
            if (v1) begin
                acc_q <= sum_nxt;
                cnt_q <= cnt_nxt;
                ovf_q <= first ? ov : (ovf_q | ov);
                first <= last1;
            end
        end
    end

    assign bus.acc       = acc_q;
    assign bus.cnt       = cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mac_pipe_acc.sv
// Bench for mac_pipe_acc: unsigned/20, signed/20 and unsigned/16 instances
// checked every cycle against an arithmetic frame model plus literal results.
module tb_mac_pipe_acc;
    logic clk;
    logic rst;

    mac_pipe_acc_if #(.DATA_W(8), .ACC_W(20), .CNT_W(8)) if0 ();
    mac_pipe_acc_if #(.DATA_W(8), .ACC_W(20), .CNT_W(8)) if1 ();
    mac_pipe_acc_if #(.DATA_W(8), .ACC_W(16), .CNT_W(8)) if2 ();

    mac_pipe_acc #(.DATA_W(8), .ACC_W(20), .CNT_W(8), .SIGNED(0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    mac_pipe_acc #(.DATA_W(8), .ACC_W(20), .CNT_W(8), .SIGNED(1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));
    mac_pipe_acc #(.DATA_W(8), .ACC_W(16), .CNT_W(8), .SIGNED(0)) u2 (.clk(clk), .rst(rst), .bus(if2.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int ovc[3];

    longint m_acc[3];
    longint m_p[3];
    int     m_cnt[3];
    bit     m_v1[3];
    bit     m_last1[3];
    bit     m_first[3];
    bit     m_ovf[3];
    bit     m_ov[3];

`ifdef MAC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int aw(input int i);
        return (i == 2) ? 16 : 20;
    endfunction

    function automatic bit sg(input int i);
        return i == 1;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic get_out(input int i, output longint ac, output longint cn,
                           output longint of, output longint ov);
        case (i)
            0: begin ac = longint'(if0.acc); cn = longint'(if0.cnt); of = longint'(if0.ovf); ov = longint'(if0.out_valid); end
            1: begin ac = longint'(if1.acc); cn = longint'(if1.cnt); of = longint'(if1.ovf); ov = longint'(if1.out_valid); end
            default: begin ac = longint'(if2.acc); cn = longint'(if2.cnt); of = longint'(if2.ovf); ov = longint'(if2.out_valid); end
        endcase
    endtask

    // Frame model: exact integer sums, range check for overflow, then
    // wrap or clamp into the accumulator width.
    task automatic model_step();
        logic       iv, il, ic;
        logic [7:0] ia, ib;
        longint     lo, hi, t, msk;
        bit         o;
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: begin iv = if0.in_valid; il = if0.in_last; ic = if0.clr; ia = if0.a; ib = if0.b; end
                1: begin iv = if1.in_valid; il = if1.in_last; ic = if1.clr; ia = if1.a; ib = if1.b; end
                default: begin iv = if2.in_valid; il = if2.in_last; ic = if2.clr; ia = if2.a; ib = if2.b; end
            endcase
            if (ic) begin
                m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_ov[i] = 0;
                m_v1[i] = 0; m_last1[i] = 0; m_first[i] = 1;
            end else begin
                m_ov[i] = m_v1[i] && m_last1[i];
                if (m_v1[i]) begin
                    msk = (64'sd1 <<< aw(i)) - 1;
                    lo  = sg(i) ? -(64'sd1 <<< (aw(i) - 1)) : 0;
                    hi  = sg(i) ? (64'sd1 <<< (aw(i) - 1)) - 1 : msk;
                    t   = (m_first[i] ? 0 : m_acc[i]) + m_p[i];
                    o   = (t > hi) || (t < lo);
                    if (!o) m_acc[i] = t;
                    else if (SAT) m_acc[i] = (t > hi) ? hi : lo;
                    else begin
                        m_acc[i] = t & msk;
                        if (m_acc[i] > hi) m_acc[i] = m_acc[i] - (msk + 1);
                    end
                    m_cnt[i]   = m_first[i] ? 1 : ((m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1);
                    m_ovf[i]   = m_first[i] ? o : (m_ovf[i] | o);
                    m_first[i] = m_last1[i];
                end
                m_v1[i]    = iv;
                m_last1[i] = iv && il;
                if (iv) m_p[i] = sg(i) ? longint'($signed(ia)) * longint'($signed(ib))
                                       : longint'(ia) * longint'(ib);
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_acc[i] = 0; m_p[i] = 0; m_cnt[i] = 0; m_v1[i] = 0;
                m_last1[i] = 0; m_first[i] = 1; m_ovf[i] = 0; m_ov[i] = 0;
            end
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        longint ac, cn, of, ov;
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                get_out(i, ac, cn, of, ov);
                chk($sformatf("d%0d.acc", i), ac, m_acc[i] & ((64'sd1 <<< aw(i)) - 1));
                chk($sformatf("d%0d.cnt", i), cn, longint'(m_cnt[i]));
                chk($sformatf("d%0d.ovf", i), of, longint'(m_ovf[i]));
                chk($sformatf("d%0d.out_valid", i), ov, longint'(m_ov[i]));
                if (ov != 0) ovc[i]++;
            end
        end
    end

    // Literal expectation for both the DUT and the model (acc as raw bits).
    task automatic hc(input string nm, input int i, input longint e_acc, input longint e_cnt,
                      input longint e_ovf, input longint e_ov);
        longint ac, cn, of, ov;
        get_out(i, ac, cn, of, ov);
        chk({nm, ".acc"}, ac, e_acc);
        chk({nm, ".cnt"}, cn, e_cnt);
        chk({nm, ".ovf"}, of, e_ovf);
        chk({nm, ".out_valid"}, ov, e_ov);
        chk({nm, ".model_acc"}, m_acc[i] & ((64'sd1 <<< aw(i)) - 1), e_acc);
    endtask

    task automatic drive(input int id, input logic v, input logic [7:0] aa, input logic [7:0] bb,
                         input logic l, input logic c);
        case (id)
            0: begin if0.in_valid = v; if0.a = aa; if0.b = bb; if0.in_last = l; if0.clr = c; end
            1: begin if1.in_valid = v; if1.a = aa; if1.b = bb; if1.in_last = l; if1.clr = c; end
            default: begin if2.in_valid = v; if2.a = aa; if2.b = bb; if2.in_last = l; if2.clr = c; end
        endcase
    endtask

    task automatic put(input int id, input logic [7:0] aa, input logic [7:0] bb, input logic l);
        drive(id, 1'b1, aa, bb, l, 1'b0);
        @(negedge clk);
    endtask

    task automatic idle(input int id, input int n);
        drive(id, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        n_bad++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ovc[i] = 0;
            drive(i, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) hc("reset", i, 0, 0, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Unsigned 4 x 255*255
        ovc[0] = 0;
        put(0, 8'd255, 8'd255, 1'b0);
        put(0, 8'd255, 8'd255, 1'b0);
        put(0, 8'd255, 8'd255, 1'b0);
        put(0, 8'd255, 8'd255, 1'b1);
        idle(0, 1);
        hc("u4x255", 0, 260100, 4, 0, 1);
        idle(0, 2);
        chk("u4x255.pulses", longint'(ovc[0]), 1);

        // Signed frames back to back
        put(1, 8'h80, 8'h80, 1'b0);
        put(1, 8'h80, 8'h7F, 1'b1);
        put(1, 8'd3, 8'hFB, 1'b1);
        hc("s_frame1", 1, 128, 2, 0, 1);
        idle(1, 1);
        hc("s_frame2", 1, 1048561, 1, 0, 1);
        idle(1, 1);

        // ACC_W=16 overflow then fresh frame
        put(2, 8'd255, 8'd255, 1'b0);
        put(2, 8'd255, 8'd255, 1'b1);
        put(2, 8'd1, 8'd1, 1'b1);
        hc("u16_ovf", 2, SAT ? 65535 : 64514, 2, 1, 1);
        idle(2, 1);
        hc("u16_next", 2, 1, 1, 0, 1);
        idle(2, 1);

        // clr with a term in S1 and a new term offered in the same cycle
        put(0, 8'd2, 8'd2, 1'b0);
        drive(0, 1'b1, 8'd9, 8'd9, 1'b1, 1'b1);
        @(negedge clk);
        hc("clr", 0, 0, 0, 0, 0);
        idle(0, 1);
        hc("clr_hold", 0, 0, 0, 0, 0);
        put(0, 8'd4, 8'd5, 1'b1);
        idle(0, 1);
        hc("after_clr", 0, 20, 1, 0, 1);

        // Term counter saturation
        for (int k = 0; k < 300; k++) put(0, 8'd1, 8'd1, (k == 299));
        idle(0, 1);
        hc("cnt_sat", 0, 300, 255, 0, 1);

        // Signed positive overflow
        for (int k = 0; k < 32; k++) put(1, 8'h80, 8'h80, (k == 31));
        idle(1, 1);
        hc("s_ovf", 1, SAT ? 524287 : 524288, 32, 1, 1);

        // Asynchronous reset mid-frame
        put(0, 8'd7, 8'd7, 1'b0);
        put(0, 8'd7, 8'd7, 1'b0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) hc("async_rst", i, 0, 0, 0, 0);
        drive(0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        put(0, 8'd2, 8'd3, 1'b1);
        idle(0, 1);
        hc("post_rst", 0, 6, 1, 0, 1);

        idle(0, 3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mac_pipe_acc.md
# mac_pipe_acc

Parametrised, two-stage pipelined multiply-accumulate unit and the next generation of the fixed 8-bit MAC. It multiplies two DATA_W operands, signed or unsigned, and accumulates the products into an ACC_W accumulator with guard bits. Accumulation is framed: a `last` marker closes a dot product and pulses `out_valid`, and the next term starts a fresh sum. It also provides a term counter and a sticky overflow flag, and sits in the datapath between operand fetch and the result writeback stage.

## Interface
- DATA_W, 8, operand width (≥2)
- ACC_W, 20, accumulator width (≥ 2*DATA_W)
- CNT_W, 8, term-counter width
- SIGNED, 0, 1 = two's-complement operands/accumulator, 0 = unsigned
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  a/b/in_last qualify this cycle
- a  in  DATA_W  operand A
- b  in  DATA_W  operand B
- in_last  in  1  this term closes the current frame
- clr  in  1  synchronous flush/clear
- acc  out  ACC_W  running accumulator (registered)
- out_valid  out  1  one-cycle pulse: `acc` holds a completed frame
- cnt  out  CNT_W  terms accumulated in current/just-closed frame
- ovf  out  1  sticky overflow for current/just-closed frame

## Operation
- Stage 1 (S1): on `in_valid`, register `p = a*b` (2*DATA_W bits, signedness per SIGNED), `v1=1`, `last1=in_last`. Otherwise `v1=0`.
- Stage 2 (S2): when `v1=1`, `base = first ? 0 : acc`, and `acc <= base + ext(p)`. `ext` sign-extends if SIGNED=1, else zero-extends, to ACC_W.
- `first`: internal flag, set by reset, by `clr`, and by S2 processing `last1`. Cleared by any other S2 term. The term after a `last` starts a new frame with no idle cycle needed.
- `cnt`: S2 term loads 1 if `first`, else increments. It saturates at 2^CNT_W−1.
- `ovf`: S2 term sets it on overflow. On a `first` term it is loaded with that term's overflow only.
- Overflow rule: unsigned means carry out of bit ACC_W−1. Signed means the operands of the add have equal signs and the result sign differs.
- `out_valid` is 1 in the cycle after S2 processes a term with `last1=1`; otherwise 0. `acc`, `cnt` and `ovf` hold their values until the next S2 term or `clr`.
- `clr`: next edge zeroes `acc`, `cnt`, `ovf`, `v1`, `out_valid` and sets `first`. It has priority over `in_valid` in the same cycle; that input is discarded. A term already in S1 is discarded.
- No backpressure: every `in_valid` cycle is accepted. Back-to-back input every cycle is supported.
- Reset values: acc=0, cnt=0, ovf=0, out_valid=0, v1=0, first=1.

## Timing
- Latency is 2 edges. A term presented at edge N is in S1 after N. It is reflected in `acc`/`cnt`/`ovf` after edge N+1, and `out_valid` (if last) is high in the cycle following edge N+1.
- Throughput is 1 term/cycle.
- Reset mid-frame: asynchronous clear of all state. Terms in flight are lost.
- If `in_last` is set on a single-term frame, that term forms a complete frame, with `cnt=1`.

## Configuration
- `MAC_SAT_EN` defined: on overflow, `acc` saturates. Unsigned saturates to 2^ACC_W−1. Signed saturates to the max-positive/max-negative value in the direction of the overflow. Subsequent adds continue from the saturated value.
- Not defined: `acc` wraps modulo 2^ACC_W.
- `ovf` behaves identically in both builds.

## Test plan
- Unsigned, DATA_W=8, ACC_W=20: 4 terms of 255*255, last on the 4th. Required: `acc`=260100, `cnt`=4, `ovf`=0, and `out_valid` high exactly once, 2 cycles after the 4th input.
- SIGNED=1: terms (−128*−128), (−128*127), last. Required: `acc`=128, `cnt`=2. Then a new frame of (3*−5) with last gives `acc`=−15 and `cnt`=1, with zero idle cycles between frames.
- Unsigned, ACC_W=16: 255*255 twice, last. Without the macro: `acc`=64514, `ovf`=1. With `MAC_SAT_EN`: `acc`=65535, `ovf`=1. A next frame of 1*1 gives `acc`=1 and `ovf`=0.
- `clr` while a term is in S1 and `in_valid`=1 in the same cycle. Required: next cycle `acc`=0, `cnt`=0, and no `out_valid`. The term after that starts a fresh frame.
- Assert `rst` mid-frame, asynchronously between edges. Required: all outputs are 0 immediately. After release, 2*3 with last gives `acc`=6 and `out_valid` pulses.
